// File: rtl/sram_ctrl.sv
// sram_ctrl
// ---------------------------------------------------------------------------
// Single-port controller between an internal one-cycle request interface and
// an external asynchronous SRAM (256K x 16 by default). Requests become timed
// CS/OE/WE strobe sequences. The data-bus tri-state buffer lives outside this
// block; it is steered by data_pins_out_en.
//
// Ports
//   clk              system clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   address          word address, sampled when a request is accepted
//   data_write       write data, sampled when a write is accepted
//   write / read     level requests, only looked at while idle (write wins)
//   ready            high while idle and able to accept a request
//   data_read        last word read; updated when a read completes
//   data_pins_out    value for the external buffer to drive onto the bus
//   data_pins_in     value sampled from the SRAM data bus
//   data_pins_out_en high = external buffer drives data_pins_out
//   address_pins     registered SRAM address bus
//   CS / OE / WE     active-low SRAM strobes (registered)
//
// Every output comes straight from a flop. The flop inputs are decoded from
// the *next* state, so the strobes change on the same edge as the state does.
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_write,
    input  logic              write,
    input  logic              read,
    output logic              ready,
    output logic [DATA_W-1:0] data_read,
    output logic [DATA_W-1:0] data_pins_out,
    input  logic [DATA_W-1:0] data_pins_in,
    output logic              data_pins_out_en,
    output logic [ADDR_W-1:0] address_pins,
    output logic              CS,
    output logic              OE,
    output logic              WE
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_SETUP = 3'd1,
        WR_PULSE = 3'd2,
        WR_HOLD  = 3'd3,
        RD_SETUP = 3'd4,
        RD_WAIT  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                cs_q, cs_d;
    logic                oe_q, oe_d;
    logic                we_q, we_d;
    logic                out_en_q, out_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W-1:0]   dread_q, dread_d;

    // -----------------------------------------------------------------------
    // Next-state and datapath capture
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        dread_d = dread_q;

        unique case (state_q)
            IDLE: begin
                // ready_q gates acceptance: the cycle right after reset is
                // IDLE but not yet ready, so a request there is not taken.
                if (ready_q) begin
                    if (write) begin
                        state_d = WR_SETUP;
                        addr_d  = address;
                        dout_d  = data_write;
                    end else if (read) begin
                        state_d = RD_SETUP;
                        addr_d  = address;
                    end
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = IDLE;
            RD_SETUP: state_d = RD_WAIT;
            RD_WAIT: begin
                // OE is still low during this cycle, so the bus carries the
                // SRAM's data at the edge that leaves RD_WAIT.
                dread_d = data_pins_in;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode from the next state
    // -----------------------------------------------------------------------
    // WE is low only in WR_PULSE, so it falls one cycle after CS/out_en and
    // rises one cycle before they release. out_en is only ever high in write
    // states, where OE is high, so the bus never sees two drivers.
    always_comb begin
        ready_d  = (state_d == IDLE);
        cs_d     = (state_d == IDLE);
        oe_d     = !((state_d == RD_SETUP) || (state_d == RD_WAIT));
        we_d     = (state_d != WR_PULSE);
        out_en_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) ||
                   (state_d == WR_HOLD);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            cs_q     <= 1'b1;
            oe_q     <= 1'b1;
            we_q     <= 1'b1;
            out_en_q <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            dread_q  <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            cs_q     <= cs_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            out_en_q <= out_en_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            dread_q  <= dread_d;
        end
    end

    assign ready            = ready_q;
    assign data_read        = dread_q;
    assign data_pins_out    = dout_q;
    assign data_pins_out_en = out_en_q;
    assign address_pins     = addr_q;
    assign CS               = cs_q;
    assign OE               = oe_q;
    assign WE               = we_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed scenarios followed by randomized operations,
// checked against a transaction-level reference (expected strobe pattern per
// cycle of each operation, plus an associative-array picture of memory).
module tb_sram_ctrl;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    // {ready, CS, OE, WE, out_en}
    localparam logic [4:0] C_IDLE  = 5'b11110;
    localparam logic [4:0] C_RST   = 5'b01110;
    localparam logic [4:0] C_WSET  = 5'b00111;
    localparam logic [4:0] C_WPUL  = 5'b00101;
    localparam logic [4:0] C_READ  = 5'b00010;
    localparam logic [DATA_W-1:0] UNWRITTEN = 16'hDEAD;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_write = '0;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic              ready;
    logic [DATA_W-1:0] data_read;
    logic [DATA_W-1:0] data_pins_out;
    logic [DATA_W-1:0] data_pins_in = '0;
    logic              data_pins_out_en;
    logic [ADDR_W-1:0] address_pins;
    logic              CS, OE, WE;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic cs_prev = 1'b1;

    // Reference state
    logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] exp_dr;

    // Behavioural SRAM on the pins
    logic [DATA_W-1:0] sram [logic [ADDR_W-1:0]];

    sram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .address(address), .data_write(data_write),
        .write(write), .read(read), .ready(ready), .data_read(data_read),
        .data_pins_out(data_pins_out), .data_pins_in(data_pins_in),
        .data_pins_out_en(data_pins_out_en), .address_pins(address_pins),
        .CS(CS), .OE(OE), .WE(WE)
    );

    always #5 clk = ~clk;

    // SRAM model: stores while CS and WE are low, drives the bus while CS and
    // OE are low, otherwise the bus floats (modelled as random junk).
    always @(negedge clk) begin
        if (!CS && !WE) sram[address_pins] = data_pins_out;
        if (!CS && !OE)
            data_pins_in = sram.exists(address_pins) ? sram[address_pins] : UNWRITTEN;
        else
            data_pins_in = DATA_W'($urandom);
    end

    // Bus/strobe safety, every cycle once out of reset
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(data_pins_out_en && !OE) && !(!WE && CS)) else begin
                errors++;
                $error("FAIL safety: out_en=%0b OE=%0b WE=%0b CS=%0b expected no contention and WE low only with CS low",
                       data_pins_out_en, OE, WE, CS);
            end
        end
        if (cs_prev && !CS) acc_cnt++;
        cs_prev = CS;
    end

    function automatic logic [4:0] ctl();
        return {ready, CS, OE, WE, data_pins_out_en};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : UNWRITTEN;
    endfunction

    // Write; "both" also raises read in the same cycle (must be dropped);
    // "late" raises a read to ra during the busy period and leaves it high.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit both, input bit late, input logic [ADDR_W-1:0] ra);
        address = a; data_write = d; write = 1'b1; read = both;
        step();
        chk("wr_setup_ctl", 32'(ctl()), 32'(C_WSET));
        chk("wr_addr", 32'(address_pins), 32'(a));
        chk("wr_data", 32'(data_pins_out), 32'(d));
        write = 1'b0; read = 1'b0;
        address = ADDR_W'($urandom); data_write = DATA_W'($urandom);
        step();
        chk("wr_pulse_ctl", 32'(ctl()), 32'(C_WPUL));
        if (late) begin address = ra; read = 1'b1; end
        step();
        chk("wr_hold_ctl", 32'(ctl()), 32'(C_WSET));
        chk("wr_hold_data", 32'(data_pins_out), 32'(d));
        ref_mem[a] = d;
        step();
        chk("wr_done_ctl", 32'(ctl()), 32'(C_IDLE));
        chk("wr_idle_addr", 32'(address_pins), 32'(a));
        chk("wr_keeps_dr", 32'(data_read), 32'(exp_dr));
    endtask

    // Read; "pre" = request already raised by the caller; "hold" keeps read
    // high until ready returns and then checks that only one access ran.
    task automatic do_read(input logic [ADDR_W-1:0] a, input bit pre, input bit hold);
        int n0;
        n0 = acc_cnt;
        if (!pre) begin address = a; read = 1'b1; end
        step();
        chk("rd_setup_ctl", 32'(ctl()), 32'(C_READ));
        chk("rd_addr", 32'(address_pins), 32'(a));
        if (!hold) read = 1'b0;
        address = ADDR_W'($urandom);
        step();
        chk("rd_wait_ctl", 32'(ctl()), 32'(C_READ));
        step();
        exp_dr = ref_rd(a);
        chk("rd_done_ctl", 32'(ctl()), 32'(C_IDLE));
        chk("rd_data", 32'(data_read), 32'(exp_dr));
        read = 1'b0;
        step();
        chk("rd_idle_ctl", 32'(ctl()), 32'(C_IDLE));
        chk("rd_one_access", 32'(acc_cnt - n0), 32'd1);
    endtask

    logic [ADDR_W-1:0] pool [8];

    initial begin
        exp_dr = '0;
        sram[18'h00005] = 16'h0A0A;
        ref_mem[18'h00005] = 16'h0A0A;
        for (int i = 0; i < 8; i++) pool[i] = ADDR_W'($urandom) & 18'h3FFFE;

        // Reset
        @(negedge clk);
        step();
        chk("rst_ctl", 32'(ctl()), 32'(C_RST));
        chk("rst_addr", 32'(address_pins), 32'd0);
        chk("rst_dout", 32'(data_pins_out), 32'd0);
        chk("rst_dr", 32'(data_read), 32'd0);
        reset = 1'b0;
        step();
        chk("rst_release_ctl", 32'(ctl()), 32'(C_IDLE));

        // Directed
        do_write(18'h00000, 16'hAAAA, 1'b0, 1'b0, '0);
        do_read(18'h00005, 1'b0, 1'b1);
        do_read(18'h00000, 1'b0, 1'b0);
        do_write(18'h00123, 16'h5A5A, 1'b0, 1'b1, 18'h00005);
        do_read(18'h00005, 1'b1, 1'b1);
        do_write(18'h00200, 16'h1234, 1'b1, 1'b0, '0);
        step();
        chk("both_no_read_ctl", 32'(ctl()), 32'(C_IDLE));

        // Reset in WR_PULSE
        address = 18'h3FFFF; data_write = 16'hBEEF; write = 1'b1;
        step();
        write = 1'b0;
        step();
        chk("abort_pulse_ctl", 32'(ctl()), 32'(C_WPUL));
        reset = 1'b1;
        step();
        chk("abort_rst_ctl", 32'(ctl()), 32'(C_RST));
        chk("abort_rst_addr", 32'(address_pins), 32'd0);
        chk("abort_rst_dout", 32'(data_pins_out), 32'd0);
        chk("abort_rst_dr", 32'(data_read), 32'd0);
        exp_dr = '0;
        reset = 1'b0;
        step();
        chk("abort_release_ctl", 32'(ctl()), 32'(C_IDLE));

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            int k;
            k = int'($urandom_range(0, 4));
            case (k)
                0: do_write(pool[$urandom_range(0, 7)], DATA_W'($urandom), 1'b0, 1'b0, '0);
                1: do_write(pool[$urandom_range(0, 7)], DATA_W'($urandom), 1'b1, 1'b0, '0);
                2: begin
                    logic [ADDR_W-1:0] ra;
                    ra = pool[$urandom_range(0, 7)];
                    do_write(pool[$urandom_range(0, 7)], DATA_W'($urandom), 1'b0, 1'b1, ra);
                    do_read(ra, 1'b1, 1'b1);
                end
                3: do_read(pool[$urandom_range(0, 7)], 1'b0, 1'b1);
                default: do_read(pool[$urandom_range(0, 7)], 1'b0, 1'b0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
